// File: rtl/binary_window_conv.sv
// Binary (XNOR/popcount) convolution stage: consumes one KxK binary window at
// a time from the sliding-window stage, compares it against a stored binary
// kernel, thresholds the match count and writes one bit per window to an
// output RAM in raster order.
module binary_window_conv #(
    parameter int IMAGE_ROW_LEN  = 32,
    parameter int IMAGE_COL_LEN  = 32,
    parameter int KERNEL_SIZE    = 3,
    parameter int STRIDE         = 1,
    parameter int OUT_ADDR_WIDTH = 10,
    localparam int KK = KERNEL_SIZE * KERNEL_SIZE,
    localparam int CW = $clog2(KK + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [KK-1:0]             win_in,
    input  logic                      win_valid,
    output logic                      slide,
    input  logic                      weight_load,
    input  logic [KK-1:0]             weight_in,
    input  logic [CW-1:0]             threshold_in,
    output logic [OUT_ADDR_WIDTH-1:0] out_w_addr,
    output logic                      out_w_data,
    output logic                      out_w_en,
    output logic                      busy,
    output logic                      done
);

    localparam int OUT_ROWS = (IMAGE_ROW_LEN - KERNEL_SIZE) / STRIDE + 1;
    localparam int OUT_COLS = (IMAGE_COL_LEN - KERNEL_SIZE) / STRIDE + 1;
    localparam int N_OUT    = OUT_ROWS * OUT_COLS;
    localparam logic [OUT_ADDR_WIDTH-1:0] LAST_ADDR = OUT_ADDR_WIDTH'(N_OUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_WIN = 3'd1,
        XNOR     = 3'd2,
        EVAL     = 3'd3,
        NEXT     = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [KK-1:0]             weights;
    logic [CW-1:0]             threshold;
    logic [OUT_ADDR_WIDTH-1:0] win_cnt;

    // Datapath pipeline: x_p0 holds the XNOR match vector, pc_p1 its popcount.
    logic [KK-1:0]             x_p0;
    logic [CW-1:0]             pc_p1;

    // Number of set bits in a match vector; range 0..KK fits in CW bits.
    function automatic logic [CW-1:0] popcount(input logic [KK-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < KK; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Binary activation: unsigned compare, so threshold 0 always fires and a
    // threshold above KK never does.
    function automatic logic activate(input logic [CW-1:0] pc,
                                      input logic [CW-1:0] thr);
        return (pc >= thr);
    endfunction

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Kernel and threshold registers, writable only while idle so a pass
    // always sees one consistent kernel.
    always_ff @(posedge clk) begin
        if (rst) begin
            weights   <= '0;
            threshold <= '0;
        end else if (state == IDLE && weight_load) begin
            weights   <= weight_in;
            threshold <= threshold_in;
        end
    end

    // Window counter doubles as the output address; it stops at the last
    // address instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt <= '0;
        end else if (state == IDLE && start) begin
            win_cnt <= '0;
        end else if (state == EVAL && win_cnt != LAST_ADDR) begin
            win_cnt <= win_cnt + OUT_ADDR_WIDTH'(1);
        end
    end

    // Stage p0: window accepted, XNOR against the kernel.
    always_ff @(posedge clk) begin
        if (state == WAIT_WIN && win_valid) begin
            x_p0 <= ~(win_in ^ weights);
        end
    end

    // Stage p1: popcount of the match vector.
    always_ff @(posedge clk) begin
        if (state == XNOR) begin
            pc_p1 <= popcount(x_p0);
        end
    end

    // Next-state logic and per-state output strobes.
    always_comb begin
        state_nxt  = state;
        slide      = 1'b0;
        out_w_en   = 1'b0;
        out_w_data = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = WAIT_WIN;
                end
            end
            WAIT_WIN: begin
                if (win_valid) begin
                    state_nxt = XNOR;
                end
            end
            XNOR: begin
                state_nxt = EVAL;
            end
            EVAL: begin
                out_w_en   = 1'b1;
                out_w_data = activate(pc_p1, threshold);
                state_nxt  = (win_cnt == LAST_ADDR) ? DONE : NEXT;
            end
            NEXT: begin
                slide     = 1'b1;
                state_nxt = WAIT_WIN;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy       = (state != IDLE);
    assign out_w_addr = win_cnt;

endmodule
